// File: rtl/cpu_pkg.sv
// Shared CPU definitions: cpustate encodings, key debounce default and
// panel bus widths. Used by the panel loader and the control unit.
package cpu_pkg;

  localparam int unsigned DEB_CYCLES_DEF = 4;
  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned DATA_W         = 8;

  // CPU state as seen by the control unit's CPUstate input
  typedef enum logic [1:0] {
    CPU_IDLE  = 2'b00,
    CPU_IN    = 2'b01,
    CPU_CHECK = 2'b10,
    CPU_RUN   = 2'b11
  } cpustate_e;

  // Mode-key sequence IDLE -> IN -> CHECK -> RUN -> IDLE
  function automatic cpustate_e next_mode(input cpustate_e s);
    cpustate_e n;
    case (s)
      CPU_IDLE:  n = CPU_IN;
      CPU_IN:    n = CPU_CHECK;
      CPU_CHECK: n = CPU_RUN;
      default:   n = CPU_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Front-panel key conditioner: 2-flop synchroniser, DEB_CYCLES stability
// filter and one-cycle press pulse on each accepted 0->1 transition.
// Ports:
//   clk, reset   clock, async active-low reset
//   key_i        raw key level, asynchronous to clk
//   press_o      registered one-cycle pulse per debounced press
module key_debounce
  import cpu_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic             meta_q, sync_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count, so a short glitch never lands.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_d = sync_q;
        press_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= key_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/panel_loader.sv
// Front-panel loader: mode key walks the CPU state IDLE->IN->CHECK->RUN;
// in IN the step key writes switch data to successive addresses, in CHECK
// it walks memory and shows each byte on the LEDs, in RUN the CPU owns memory.
// Ports:
//   clk, reset          clock, async active-low reset
//   mode_key, step_key  raw front-panel buttons, active-high
//   sw_data             data switches
//   mem_rdata           memory read data (one cycle after mem_re/address)
//   cpustate            current CPU state
//   mem_addr/wdata/we/re panel memory access
//   mem_sel             memory port owner, 1 = CPU
//   disp_data           LED byte
module panel_loader
  import cpu_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_key,
  input  logic              step_key,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        cpustate,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              mem_sel,
  output logic [DATA_W-1:0] disp_data
);

  logic mode_press, step_press;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
    .clk     (clk),
    .reset   (reset),
    .key_i   (mode_key),
    .press_o (mode_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .clk     (clk),
    .reset   (reset),
    .key_i   (step_key),
    .press_o (step_press)
  );

  cpustate_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] disp_q, disp_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              sel_q, sel_d;

  // Next state, address counter and output registers; mode beats step.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    disp_d  = disp_q;
    we_d    = 1'b0;
    if (mode_press) begin
      state_d = next_mode(state_q);
      if (state_d == CPU_IN || state_d == CPU_CHECK) begin
        addr_d = '0;
      end
    end else begin
      case (state_q)
        CPU_IN: begin
          // Address moves on only after the strobe has gone out with the old value
          if (we_q) begin
            addr_d = addr_q + ADDR_W'(1);
          end
          if (step_press) begin
            we_d    = 1'b1;
            wdata_d = sw_data;
            disp_d  = sw_data;
          end
        end
        CPU_CHECK: begin
          // Track read data continuously so the LEDs follow the current address
          if (re_q) begin
            disp_d = mem_rdata;
          end
          if (step_press) begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
    re_d  = (state_d == CPU_CHECK);
    sel_d = (state_d == CPU_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CPU_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      disp_q  <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      disp_q  <= disp_d;
      we_q    <= we_d;
      re_q    <= re_d;
      sel_q   <= sel_d;
    end
  end

  assign cpustate  = state_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign mem_sel   = sel_q;
  assign disp_data = disp_q;

endmodule

// File: tb/tb_panel_loader.sv
// Bench for panel_loader: directed scenarios plus random key traffic,
// checked against an abstract model of the front panel.
module tb_panel_loader;
  import cpu_pkg::*;

  localparam int unsigned DEB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode_key, step_key;
  logic [7:0]  sw_data;
  logic [7:0]  mem_rdata = 8'h00;
  logic [1:0]  cpustate;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re, mem_sel;
  logic [7:0]  disp_data;

  always #5 clk = ~clk;

  panel_loader #(.DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_key  (mode_key),
    .step_key  (step_key),
    .sw_data   (sw_data),
    .mem_rdata (mem_rdata),
    .cpustate  (cpustate),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_sel   (mem_sel),
    .disp_data (disp_data)
  );

  // Synchronous memory attached to the panel port
  logic [7:0] mem [0:65535];
  initial for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: state index 0..3, counter, memory contents
  int          m_state;
  logic [15:0] m_cnt;
  logic [7:0]  m_mem [logic [15:0]];
  logic [7:0]  m_last;
  bit          m_wrote;
  int          exp_wr = 0;

  function automatic logic [7:0] exp_byte(input logic [15:0] a);
    if (m_mem.exists(a)) return m_mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t wq[$];
  wr_t mon_e;
  int  wr_cnt = 0;

  // Write monitor: every mem_we cycle must match the next expected write
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      wr_cnt++;
      if (wq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
      end else begin
        mon_e = wq.pop_front();
        check("write_addr", 32'(mem_addr), 32'(mon_e.a));
        check("write_data", 32'(mem_wdata), 32'(mon_e.d));
      end
    end
  end

  task automatic model_mode();
    m_state = (m_state + 1) % 4;
    if (m_state == 1 || m_state == 2) m_cnt = 16'h0000;
    m_wrote = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] d);
    if (m_state == 1) begin
      wq.push_back('{a: m_cnt, d: d});
      m_mem[m_cnt] = d;
      m_last  = d;
      m_wrote = 1'b1;
      exp_wr++;
      m_cnt = m_cnt + 16'h0001;
    end else if (m_state == 2) begin
      m_cnt = m_cnt + 16'h0001;
    end
  endtask

  task automatic press(input bit md, input bit st, input int hold);
    @(negedge clk);
    mode_key = md;
    step_key = st;
    repeat (hold) @(negedge clk);
    mode_key = 1'b0;
    step_key = 1'b0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic do_mode(input int hold);
    press(1'b1, 1'b0, hold);
    model_mode();
  endtask

  task automatic do_step(input logic [7:0] d, input int hold);
    sw_data = d;
    model_step(d);
    press(1'b0, 1'b1, hold);
  endtask

  task automatic glitch(input bit md, input int len);
    @(negedge clk);
    if (md) mode_key = 1'b1; else step_key = 1'b1;
    repeat (len) @(negedge clk);
    mode_key = 1'b0;
    step_key = 1'b0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic check_outputs();
    check("cpustate", 32'(cpustate), 32'(m_state));
    check("mem_addr", 32'(mem_addr), 32'(m_cnt));
    check("mem_sel", 32'(mem_sel), 32'(m_state == 3));
    check("mem_re", 32'(mem_re), 32'(m_state == 2));
    check("mem_we_idle", 32'(mem_we), 32'(0));
    if (m_state == 2) check("disp_check", 32'(disp_data), 32'(exp_byte(m_cnt)));
    if (m_state == 1 && m_wrote) check("disp_in", 32'(disp_data), 32'(m_last));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpustate"}, 32'(cpustate), 32'(0));
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
    check({tag, "_mem_we"}, 32'(mem_we), 32'(0));
    check({tag, "_mem_re"}, 32'(mem_re), 32'(0));
    check({tag, "_mem_sel"}, 32'(mem_sel), 32'(0));
    check({tag, "_disp"}, 32'(disp_data), 32'(0));
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    bool_seen_t: begin end
    reset = 1'b0; mode_key = 1'b0; step_key = 1'b0; sw_data = 8'h00;
    m_state = 0; m_cnt = 16'h0000; m_wrote = 1'b0; m_last = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Mode sequence IDLE -> IN -> CHECK -> RUN -> IDLE
    for (int i = 0; i < 4; i++) begin
      do_mode(DEB + 2);
      check_outputs();
    end

    // IN: two writes
    do_mode(DEB + 2);
    base = wr_cnt;
    do_step(8'hA5, DEB + 3);
    check_outputs();
    do_step(8'h3C, DEB + 5);
    check_outputs();
    check("two_writes", 32'(wr_cnt - base), 32'(2));
    check("cnt_after_two", 32'(mem_addr), 32'h0002);

    // Glitch is rejected; long hold gives one write
    base = wr_cnt;
    sw_data = 8'h77;
    glitch(1'b0, 2);
    check("glitch_no_write", 32'(wr_cnt - base), 32'(0));
    check_outputs();
    do_step(8'h6E, 100);
    check("hold_one_write", 32'(wr_cnt - base), 32'(1));
    check_outputs();

    // Counter wrap at 0xFFFF
    @(negedge clk);
    force dut.addr_q = 16'hFFFF;
    @(negedge clk);
    release dut.addr_q;
    m_cnt = 16'hFFFF;
    base = wr_cnt;
    do_step(8'hE1, DEB + 2);
    check("wrap_write", 32'(wr_cnt - base), 32'(1));
    check("wrap_cnt", 32'(mem_addr), 32'h0000);
    check_outputs();

    // CHECK: display walks memory
    do_mode(DEB + 2);
    check("check_disp0", 32'(disp_data), 32'h00A5);
    do_step(8'h00, DEB + 2);
    check("check_disp1", 32'(disp_data), 32'h003C);
    check_outputs();

    // Back to IN, then mode and step together
    do_mode(DEB + 2);
    do_mode(DEB + 2);
    do_mode(DEB + 2);
    check_outputs();
    base = wr_cnt;
    sw_data = 8'h42;
    press(1'b1, 1'b1, DEB + 3);
    model_mode();
    check("same_cycle_no_write", 32'(wr_cnt - base), 32'(0));
    check_outputs();

    // Reset during a write strobe
    do_mode(DEB + 2);
    do_mode(DEB + 2);
    do_mode(DEB + 2);
    check_outputs();
    sw_data = 8'h99;
    @(negedge clk);
    step_key = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (mem_we === 1'b1) break;
    end
    check("we_before_reset", 32'(mem_we), 32'(1));
    reset = 1'b0;
    #1;
    check_all_zero("midwrite");
    step_key = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_state = 0; m_cnt = 16'h0000; m_wrote = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs();

    // Random key traffic
    for (int n = 0; n < 60; n++) begin
      int op;
      op = int'($urandom_range(0, 5));
      case (op)
        0, 1: do_mode(int'($urandom_range(DEB + 1, DEB + 10)));
        2, 3: do_step(8'($urandom), int'($urandom_range(DEB + 1, DEB + 10)));
        4:    glitch(1'b0, int'($urandom_range(1, DEB - 2)));
        default: glitch(1'b1, int'($urandom_range(1, DEB - 2)));
      endcase
      check_outputs();
    end

    repeat (5) @(negedge clk);
    check("pending_writes", 32'(wq.size()), 32'(0));
    check("write_count", 32'(wr_cnt), 32'(exp_wr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
